// File: rtl/rram_read_capture.sv
// rram_read_capture
// Captures sense-amp words on each rising edge of sa_rdy while a read is
// armed, tags them with rram_addr and queues them in a first-word-fall-through
// FIFO for the slow SPI readback path.
// Optional feature macro: READ_CAPTURE_ERR_CNT_EN enables the saturating
// mismatched-bit counter on err_cnt (otherwise err_cnt is tied to zero).
module rram_read_capture #(
  parameter int WORD_W     = 48,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic              cap_en,
  input  logic              clr,
  input  logic [ADDR_W-1:0] rram_addr,
  input  logic              sa_rdy,
  input  logic [WORD_W-1:0] sa_do,
  input  logic [WORD_W-1:0] di,
  input  logic              rd_pop,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow,
  output logic [15:0]       err_cnt
);

  localparam int IDX_W   = $clog2(FIFO_DEPTH);
  localparam int PTR_W   = IDX_W + 1;
  localparam int ENTRY_W = ADDR_W + WORD_W;

  typedef enum logic {
    IDLE,
    ARMED
  } cap_state_t;

  cap_state_t state;
  logic sa_rdy_q;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0] head;
  logic [PTR_W-1:0] wptr, rptr, wptr_nxt, rptr_nxt;
  logic empty, full, capture, do_pop, do_write, drop;

  // Capture fires on a sa_rdy rise seen only while armed; pops are only
  // honoured when there is something to pop, and a full FIFO accepts a new
  // entry only if the head leaves in the same cycle.
  assign empty    = (wptr == rptr);
  assign full     = (wptr[IDX_W] != rptr[IDX_W]) &&
                    (wptr[IDX_W-1:0] == rptr[IDX_W-1:0]);
  assign capture  = (state == ARMED) && sa_rdy && !sa_rdy_q;
  assign do_pop   = rd_pop && !empty;
  assign do_write = capture && (!full || do_pop);
  assign drop     = capture && full && !do_pop;
  assign wptr_nxt = wptr + PTR_W'(do_write);
  assign rptr_nxt = rptr + PTR_W'(do_pop);

  // Head entry falls through combinationally; outputs read zero when empty
  // so stale or never-written storage is never exposed.
  assign head     = mem[rptr[IDX_W-1:0]];
  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : head[WORD_W-1:0];
  assign rd_addr  = empty ? '0 : head[ENTRY_W-1:WORD_W];

  // Arming follows cap_en one cycle later; edges seen while idle are lost.
  always_ff @(posedge mclk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (cap_en)  state <= ARMED;
        ARMED:   if (!cap_en) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Registered copy of sa_rdy for rising-edge detection.
  always_ff @(posedge mclk) begin
    if (rst) sa_rdy_q <= 1'b0;
    else     sa_rdy_q <= sa_rdy;
  end

  // Storage has no reset; the pointers alone define which entries are live.
  always_ff @(posedge mclk) begin
    if (do_write) mem[wptr[IDX_W-1:0]] <= {rram_addr, sa_do};
  end

  // Pointers and level move together so fifo_level is always consistent.
  always_ff @(posedge mclk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
    end else begin
      wptr       <= wptr_nxt;
      rptr       <= rptr_nxt;
      fifo_level <= LVL_W'(wptr_nxt - rptr_nxt);
    end
  end

  // Sticky drop flag; a clear in the same cycle as a drop takes priority.
  always_ff @(posedge mclk) begin
    if (rst)       overflow <= 1'b0;
    else if (clr)  overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

`ifdef READ_CAPTURE_ERR_CNT_EN
  localparam int PC_W = $clog2(WORD_W + 1);

  function automatic logic [PC_W-1:0] popcount(input logic [WORD_W-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < WORD_W; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  logic [PC_W-1:0] mismatch_bits;
  logic [16:0]     err_sum;

  assign mismatch_bits = popcount(sa_do ^ di);
  assign err_sum       = {1'b0, err_cnt} + 17'(mismatch_bits);

  // Every capture event counts, including dropped ones; the count sticks
  // at all-ones instead of wrapping, and clear beats a concurrent add.
  always_ff @(posedge mclk) begin
    if (rst)          err_cnt <= 16'h0;
    else if (clr)     err_cnt <= 16'h0;
    else if (capture) err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end
`else
  logic unused_di;

  assign unused_di = ^di;
  assign err_cnt   = 16'h0;
`endif

endmodule

// File: tb/tb_rram_read_capture.sv
// tb_rram_read_capture
// Directed-vector bench for rram_read_capture. Honours the
// READ_CAPTURE_ERR_CNT_EN macro when choosing err_cnt expectations.
module tb_rram_read_capture;

  localparam int WORD_W     = 48;
  localparam int ADDR_W     = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int LVL_W      = 4;

`ifdef READ_CAPTURE_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              mclk;
  logic              rst;
  logic              cap_en;
  logic              clr;
  logic [ADDR_W-1:0] rram_addr;
  logic              sa_rdy;
  logic [WORD_W-1:0] sa_do;
  logic [WORD_W-1:0] di;
  logic              rd_pop;
  logic              rd_valid;
  logic [WORD_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [LVL_W-1:0]  fifo_level;
  logic              overflow;
  logic [15:0]       err_cnt;

  int total = 0;
  int bad   = 0;

  rram_read_capture #(
    .WORD_W(WORD_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)
  ) dut (
    .mclk(mclk), .rst(rst), .cap_en(cap_en), .clr(clr),
    .rram_addr(rram_addr), .sa_rdy(sa_rdy), .sa_do(sa_do), .di(di),
    .rd_pop(rd_pop), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_addr(rd_addr), .fifo_level(fifo_level), .overflow(overflow),
    .err_cnt(err_cnt)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive control inputs, advance one edge, settle past it.
  task automatic applyStimulus(input logic cap, input logic rdy,
                               input logic pop, input logic clrIn);
    cap_en = cap;
    sa_rdy = rdy;
    rd_pop = pop;
    clr    = clrIn;
    @(posedge mclk);
    #1;
  endtask

  // One armed capture: sa_rdy rises for a cycle then falls.
  task automatic pushWord(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
    rram_addr = a;
    sa_do     = d;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [15:0] expErr(input logic [15:0] v);
    return ERR_EN ? v : 16'h0;
  endfunction

  logic [WORD_W-1:0] wd;

  initial begin
    rst = 1'b1; cap_en = 1'b1; sa_rdy = 1'b1; clr = 1'b0; rd_pop = 1'b0;
    rram_addr = '0; sa_do = '0; di = '0;

    // Reset with sa_rdy and cap_en high
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_valid", rd_valid, 0);
    checkOutput("rst_data", rd_data, 0);
    checkOutput("rst_addr", rd_addr, 0);
    checkOutput("rst_level", fifo_level, 0);
    checkOutput("rst_ovf", overflow, 0);
    checkOutput("rst_err", err_cnt, 0);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("held_rdy_level", fifo_level, 0);
    checkOutput("held_rdy_valid", rd_valid, 0);

    // Long sa_rdy pulse gives exactly one entry
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    rram_addr = 16'h0005;
    sa_do     = 48'h0000_1234_5678;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("pulse_valid", rd_valid, 1);
    checkOutput("pulse_addr", rd_addr, 16'h0005);
    checkOutput("pulse_data", rd_data, 48'h0000_1234_5678);
    checkOutput("pulse_level1", fifo_level, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("pulse_level_hold", fifo_level, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("pulse_pop_valid", rd_valid, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("empty_pop_level", fifo_level, 0);

    // Fill, overflow, drain in order
    for (int i = 0; i < 8; i++) begin
      wd = 48'hA000_0000_0000 | 48'(i);
      pushWord(16'(i), wd);
    end
    checkOutput("fill_level", fifo_level, 8);
    checkOutput("fill_no_ovf", overflow, 0);
    pushWord(16'd8, 48'hA000_0000_0008);
    checkOutput("ovf_level", fifo_level, 8);
    checkOutput("ovf_set", overflow, 1);
    for (int i = 0; i < 8; i++) begin
      wd = 48'hA000_0000_0000 | 48'(i);
      checkOutput($sformatf("drain_addr%0d", i), rd_addr, 16'(i));
      checkOutput($sformatf("drain_data%0d", i), rd_data, wd);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    end
    checkOutput("drain_valid", rd_valid, 0);
    checkOutput("drain_level", fifo_level, 0);
    checkOutput("ovf_sticky", overflow, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("ovf_clr", overflow, 0);

    // Empty with capture and pop together
    rram_addr = 16'h0042;
    sa_do     = 48'h42;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("empty_cp_level", fifo_level, 1);
    checkOutput("empty_cp_addr", rd_addr, 16'h0042);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("empty_cp_drain", fifo_level, 0);

    // Full with capture and pop together
    for (int i = 0; i < 8; i++) pushWord(16'(i), 48'(i));
    checkOutput("full_cp_head", rd_addr, 16'h0000);
    rram_addr = 16'h0099;
    sa_do     = 48'h99;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("full_cp_level", fifo_level, 8);
    checkOutput("full_cp_ovf", overflow, 0);
    checkOutput("full_cp_newhead", rd_addr, 16'h0001);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("full_cp_tail_addr", rd_addr, 16'h0099);
    checkOutput("full_cp_tail_data", rd_data, 48'h99);
    checkOutput("full_cp_tail_level", fifo_level, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("full_cp_empty", rd_valid, 0);

    // Mismatch counting and saturation
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    rram_addr = 16'h0055;
    sa_do     = 48'hF3;
    di        = 48'h01;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("err_small", err_cnt, expErr(16'd5));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("err_clr", err_cnt, 0);
    di = '0;
    for (int i = 0; i < 1365; i++) pushWord(16'h0077, 48'hFFFF_FFFF_FFFF);
    checkOutput("err_1365", err_cnt, expErr(16'hFFF0));
    checkOutput("err_ovf", overflow, 1);
    pushWord(16'h0077, 48'hFFFF_FFFF_FFFF);
    checkOutput("err_sat", err_cnt, expErr(16'hFFFF));
    pushWord(16'h0077, 48'hFFFF_FFFF_FFFF);
    checkOutput("err_sat_hold", err_cnt, expErr(16'hFFFF));
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("clr_wins_err", err_cnt, 0);
    checkOutput("clr_wins_ovf", overflow, 0);
    checkOutput("clr_full_level", fifo_level, 8);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // Idle captures ignored, then reset discards queued entries
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("flush_level", fifo_level, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("idle_level", fifo_level, 0);
    checkOutput("idle_valid", rd_valid, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    pushWord(16'h0100, 48'h100);
    pushWord(16'h0101, 48'h101);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("midstream_level", fifo_level, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    pushWord(16'h0102, 48'h102);
    checkOutput("three_level", fifo_level, 3);
    checkOutput("three_head", rd_addr, 16'h0100);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_mid_valid", rd_valid, 0);
    checkOutput("rst_mid_level", fifo_level, 0);
    checkOutput("rst_mid_data", rd_data, 0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
